// File: rtl/lbdr_port_allocator_pkg.sv
// Shared definitions for the LBDR switch allocator: flit types, port indices
// and the per-output allocation state.
package lbdr_port_allocator_pkg;

  localparam logic [2:0] HEADER  = 3'd1;
  localparam logic [2:0] PAYLOAD = 3'd2;
  localparam logic [2:0] TAIL    = 3'd3;

  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_W = 2;
  localparam int PORT_S = 3;
  localparam int PORT_L = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/lbdr_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, with wrap.
module lbdr_rr_arbiter #(
  parameter int NUM_PORTS = 5
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [2:0]           ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [2:0]           idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    // indices above the pointer first, then wrap to the lowest set request
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!found && req[j] && (j > int'(ptr))) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = 3'(j);
      end
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = 3'(j);
      end
    end
  end

endmodule

// File: rtl/lbdr_port_allocator.sv
// Wormhole switch allocator: round-robin per output, grant held HEADER..TAIL,
// flit transfers gated by downstream credits. Optional ALLOC_TIMEOUT_EN adds idle-owner release.
module lbdr_port_allocator
  import lbdr_port_allocator_pkg::*;
#(
  parameter int NUM_PORTS    = 5,
  parameter int CREDIT_DEPTH = 4,
  parameter int TIMEOUT_CYC  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           in_valid,
  input  logic [3*NUM_PORTS-1:0]         in_flit_id,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0]           credit_in,
  output logic [NUM_PORTS-1:0]           in_ready,
  output logic [NUM_PORTS-1:0]           out_valid,
  output logic [3*NUM_PORTS-1:0]         out_sel,
`ifdef ALLOC_TIMEOUT_EN
  output logic [NUM_PORTS-1:0]           timeout,
`endif
  output logic [NUM_PORTS-1:0]           busy
);

  localparam int CW = $clog2(CREDIT_DEPTH + 1);
`ifdef ALLOC_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
`endif

  if (NUM_PORTS > 8 || CREDIT_DEPTH < 1 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("lbdr_port_allocator: unsupported parameter values");
  end

  logic [NUM_PORTS-1:0][2:0] flit, dec_idx, owner;
  logic [NUM_PORTS-1:0]      dec_vld, owned, xfer;

  // Lowest set bit of each request slice wins; extra bits are ignored
  always_comb begin
    dec_vld = '0;
    dec_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      flit[i] = in_flit_id[3*i +: 3];
      for (int o = NUM_PORTS-1; o >= 0; o--) begin
        if (req[i*NUM_PORTS + o]) begin
          dec_vld[i] = 1'b1;
          dec_idx[i] = 3'(o);
        end
      end
    end
  end

  always_comb begin
    owned = '0;
    for (int o = 0; o < NUM_PORTS; o++)
      if (busy[o]) owned[owner[o]] = 1'b1;
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    alloc_state_t         state, state_nxt;
    logic [2:0]           owner_q, rr_ptr, win;
    logic [CW-1:0]        credit;
    logic [NUM_PORTS-1:0] elig, gnt;
    logic                 tail, rel;

    always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_PORTS; i++)
        elig[i] = in_valid[i] && (flit[i] == HEADER) && dec_vld[i] &&
                  (dec_idx[i] == 3'(o)) && !owned[i];
    end

    lbdr_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
      .req (elig),
      .ptr (rr_ptr),
      .gnt (gnt),
      .idx (win)
    );

    assign owner[o] = owner_q;
    assign busy[o]  = (state == BUSY);
    assign xfer[o]  = (state == BUSY) && in_valid[owner_q] && (credit != '0);
    assign tail     = (flit[owner_q] == TAIL);

`ifdef ALLOC_TIMEOUT_EN
    logic [SW-1:0] stall;
    logic          stall_hit, to_q;

    assign stall_hit  = (state == BUSY) && !in_valid[owner_q] && (stall == SW'(TIMEOUT_CYC - 1));
    assign timeout[o] = to_q;
    assign rel        = (xfer[o] && tail) || stall_hit;

    always_ff @(posedge clk) begin
      if (rst) begin
        stall <= '0;
        to_q  <= 1'b0;
      end else begin
        to_q <= stall_hit;
        if (state != BUSY || xfer[o] || stall_hit) stall <= '0;
        else if (!in_valid[owner_q])               stall <= stall + SW'(1);
      end
    end
`else
    assign rel = xfer[o] && tail;
`endif

    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:    if (|gnt) state_nxt = BUSY;
        BUSY:    if (rel)  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= IDLE;
        owner_q <= '0;
        rr_ptr  <= 3'(NUM_PORTS - 1);
        credit  <= CW'(CREDIT_DEPTH);
      end else begin
        state <= state_nxt;
        if (state == IDLE && |gnt) owner_q <= win;
        if (rel)                   rr_ptr  <= owner_q;
        // simultaneous transfer and returned credit cancel out
        if (xfer[o] && !credit_in[o])
          credit <= credit - CW'(1);
        else if (!xfer[o] && credit_in[o] && credit != CW'(CREDIT_DEPTH))
          credit <= credit + CW'(1);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    out_sel  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (xfer[o]) begin
        in_ready[owner[o]] = 1'b1;
        out_sel[3*o +: 3]  = owner[o];
      end
    end
  end

  assign out_valid = xfer;

endmodule

// File: tb/tb_lbdr_port_allocator.sv
// Bench for lbdr_port_allocator: per-input flit queues feed the DUT, a packet-level
// model predicts grants/transfers each cycle, directed tests pin literal results.
module tb_lbdr_port_allocator;
  import lbdr_port_allocator_pkg::*;

  localparam int NP = 5;
  localparam int CD = 4;

  typedef struct packed {
    logic [2:0] fid;
    logic [4:0] rq;
  } flit_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  in_valid = '0;
  logic [14:0] in_flit_id = '0;
  logic [24:0] req = '0;
  logic [4:0]  credit_in;
  logic [4:0]  man_cr = '0, auto_cr = '0;
  logic [4:0]  in_ready, out_valid, busy;
  logic [14:0] out_sel;
`ifdef ALLOC_TIMEOUT_EN
  logic [4:0]  timeout;
`endif

  flit_t q[NP][$];
  int    dlog[NP][$];
  int    own[NP], rr[NP], cred[NP];
  bit    started = 1'b0;
  int    nchk = 0, nfail = 0;

  always #5 clk = ~clk;

  // downstream returns a slot either by hand or in the same cycle a flit leaves
  assign credit_in = man_cr | (auto_cr & out_valid);

  lbdr_port_allocator #(.NUM_PORTS(NP), .CREDIT_DEPTH(CD), .TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_flit_id (in_flit_id),
    .req        (req),
    .credit_in  (credit_in),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_sel    (out_sel),
`ifdef ALLOC_TIMEOUT_EN
    .timeout    (timeout),
`endif
    .busy       (busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int low_req(input logic [4:0] r);
    for (int o = 0; o < NP; o++) if (r[o]) return o;
    return -1;
  endfunction

  function automatic bit mxfer(input int o);
    return own[o] >= 0 && in_valid[own[o]] && cred[o] > 0;
  endfunction

  // Packet-level model: owner per output (-1 = free), rr pointer, credit count
  task automatic model_step();
    bit was_owner[NP];
    if (rst) begin
      for (int o = 0; o < NP; o++) begin own[o] = -1; rr[o] = NP-1; cred[o] = CD; end
      started = 1'b1;
      return;
    end
    for (int i = 0; i < NP; i++) was_owner[i] = 1'b0;
    for (int o = 0; o < NP; o++) if (own[o] >= 0) was_owner[own[o]] = 1'b1;
    for (int o = 0; o < NP; o++) begin
      bit x, got;
      x = mxfer(o);
      if (own[o] >= 0) begin
        if (x) begin
          if (q[own[o]].size() > 0) void'(q[own[o]].pop_front());
          if (in_flit_id[3*own[o] +: 3] == TAIL) begin rr[o] = own[o]; own[o] = -1; end
        end
      end else begin
        got = 1'b0;
        for (int k = 1; k <= NP; k++) begin
          int i;
          i = (rr[o] + k) % NP;
          if (!got && in_valid[i] && in_flit_id[3*i +: 3] == HEADER &&
              low_req(req[5*i +: 5]) == o && !was_owner[i]) begin
            own[o] = i;
            got = 1'b1;
          end
        end
      end
      if (x && !credit_in[o]) cred[o]--;
      else if (!x && credit_in[o] && cred[o] < CD) cred[o]++;
    end
  endtask

  always @(posedge clk) model_step();

  // input FIFOs present their head flit just after each edge
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (q[i].size() > 0) begin
        in_valid[i] = 1'b1;
        in_flit_id[3*i +: 3] = q[i][0].fid;
        req[5*i +: 5] = q[i][0].rq;
      end else begin
        in_valid[i] = 1'b0;
        in_flit_id[3*i +: 3] = 3'd0;
        req[5*i +: 5] = 5'd0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [4:0]  e_rdy, e_val, e_busy;
      logic [14:0] e_sel;
      e_rdy = '0; e_val = '0; e_busy = '0; e_sel = '0;
      for (int o = 0; o < NP; o++) begin
        e_busy[o] = own[o] >= 0;
        if (mxfer(o)) begin
          e_val[o] = 1'b1;
          e_rdy[own[o]] = 1'b1;
          e_sel[3*o +: 3] = 3'(own[o]);
        end
      end
      chk("in_ready", in_ready, e_rdy);
      chk("out_valid", out_valid, e_val);
      chk("out_sel", out_sel, e_sel);
      chk("busy", busy, e_busy);
      for (int o = 0; o < NP; o++)
        if (out_valid[o]) dlog[o].push_back(int'(out_sel[3*o +: 3]));
    end
  end

  task automatic push_flit(input int i, input logic [2:0] f, input logic [4:0] r);
    flit_t fl;
    fl.fid = f;
    fl.rq  = r;
    q[i].push_back(fl);
  endtask

  task automatic push_pkt(input int i, input int n, input logic [4:0] r);
    push_flit(i, HEADER, r);
    for (int k = 0; k < n-2; k++) push_flit(i, PAYLOAD, r);
    push_flit(i, TAIL, r);
  endtask

  // transfer log as hex digits, each entry stored as input index + 1
  function automatic int pack_log(input int o);
    int p;
    p = 0;
    foreach (dlog[o][k]) p = (p << 4) | (dlog[o][k] + 1);
    return p;
  endfunction

  task automatic clear_logs();
    for (int o = 0; o < NP; o++) dlog[o].delete();
  endtask

  task automatic pulse(input int o);
    man_cr[o] = 1'b1;
    @(negedge clk);
    man_cr[o] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    bit pend;
    n = 0;
    @(negedge clk);
    forever begin
      pend = 1'b0;
      for (int i = 0; i < NP; i++) if (q[i].size() > 0) pend = 1'b1;
      if ((!pend && busy == 5'd0) || n >= 80) break;
      @(negedge clk);
      n++;
    end
    chk("idle_wait_bound", int'(n < 80), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_sel", out_sel, 0);

    // single packet 0 -> E
    clear_logs();
    push_pkt(0, 3, 5'b00010);
    @(negedge clk);
    chk("t1_busy_hdr_cycle", busy[1], 0);
    @(negedge clk);
    chk("t1_busy_after_hdr", busy[1], 1);
    chk("t1_first_xfer", out_valid[1], 1);
    chk("t1_first_sel", out_sel[5:3], 0);
    wait_idle();
    chk("t1_log", pack_log(1), 32'h111);
    chk("t1_credit", cred[1], 1);
    repeat (4) pulse(1);
    chk("t1_credit_sat", cred[1], 4);

    // contention on S: 1,2,3 then 1 again
    clear_logs();
    auto_cr = 5'b01000;
    push_pkt(1, 2, 5'b01000);
    push_pkt(2, 2, 5'b01000);
    push_pkt(3, 2, 5'b01000);
    push_pkt(1, 2, 5'b01000);
    wait_idle();
    chk("t2_order", pack_log(3), 32'h22334422);
    auto_cr = '0;

    // credit stall on N
    clear_logs();
    push_pkt(4, 6, 5'b00001);
    repeat (10) @(negedge clk);
    chk("t3_four_xfers", pack_log(0), 32'h5555);
    chk("t3_still_busy", busy[0], 1);
    chk("t3_stalled", in_ready[4], 0);
    pulse(0);
    repeat (2) @(negedge clk);
    chk("t3_one_per_credit", pack_log(0), 32'h55555);
    pulse(0);
    wait_idle();
    chk("t3_done", pack_log(0), 32'h555555);
    chk("t3_credit_zero", cred[0], 0);
    repeat (4) pulse(0);

    // credit return coinciding with a transfer on W at credit 2
    clear_logs();
    push_flit(1, HEADER, 5'b00100);
    push_flit(1, PAYLOAD, 5'b00100);
    repeat (6) @(negedge clk);
    chk("t4_two_xfers", pack_log(2), 32'h22);
    chk("t4_credit_two", cred[2], 2);
    push_flit(1, TAIL, 5'b00100);
    @(negedge clk);
    man_cr[2] = 1'b1;
    chk("t4_coincident_xfer", out_valid[2], 1);
    @(negedge clk);
    man_cr[2] = 1'b0;
    chk("t4_credit_held", cred[2], 2);
    repeat (3) pulse(2);
    chk("t4_credit_sat", cred[2], 4);
    clear_logs();
    push_pkt(0, 6, 5'b00100);
    repeat (10) @(negedge clk);
    chk("t4_sat_limits_xfers", pack_log(2), 32'h1111);
    repeat (2) pulse(2);
    wait_idle();
    repeat (4) pulse(2);

    // parallel grants and malformed request
    auto_cr = '1;
    push_pkt(0, 2, 5'b00001);
    push_pkt(1, 2, 5'b10000);
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (busy == 5'd0 && n < 10);
    end
    chk("t5_parallel_grant", busy, 5'b10001);
    wait_idle();
    clear_logs();
    push_pkt(2, 2, 5'b00110);
    wait_idle();
    chk("t5_malformed_E", pack_log(1), 32'h33);
    chk("t5_malformed_not_W", pack_log(2), 0);
    auto_cr = '0;

    // reset in the middle of a packet on E
    clear_logs();
    push_flit(0, HEADER, 5'b00010);
    push_flit(0, PAYLOAD, 5'b00010);
    repeat (5) @(negedge clk);
    chk("t6_busy_before_rst", busy[1], 1);
    rst = 1'b1;
    for (int i = 0; i < NP; i++) q[i].delete();
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_credit", cred[1], 4);
    clear_logs();
    push_pkt(3, 2, 5'b00010);
    wait_idle();
    chk("t6_new_grant", pack_log(1), 32'h44);

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
